// File: rtl/ncl_sync_fifo_bridge.sv
// Dual-rail NCL input stage that samples tokens into the clk domain and queues the decoded
// words in a small FIFO with a single-rail valid/ready output and 4-phase DATA/NULL backpressure.
module ncl_sync_fifo_bridge #(
  parameter int WIDTH       = 8,
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [WIDTH-1:0]         in_t,
  input  logic [WIDTH-1:0]         in_f,
  output logic                     in_ack,
  output logic [WIDTH-1:0]         out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     err
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic {
    WAIT_DATA = 1'b0,
    WAIT_NULL = 1'b1
  } state_e;

  logic [WIDTH-1:0] sync_t_q [SYNC_STAGES];
  logic [WIDTH-1:0] sync_f_q [SYNC_STAGES];
  logic [WIDTH-1:0] prev_t_q, prev_f_q;
  logic [WIDTH-1:0] s_t, s_f;
  logic             stable, illegal, cdata, cnull;

  state_e           state_q, state_d;
  logic             push, pop, full;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]    level_q, level_d;
  logic             out_valid_q, out_valid_d;
  logic             err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_t_q[i] <= '0;
        sync_f_q[i] <= '0;
      end
      prev_t_q <= '0;
      prev_f_q <= '0;
    end else begin
      sync_t_q[0] <= in_t;
      sync_f_q[0] <= in_f;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_t_q[i] <= sync_t_q[i-1];
        sync_f_q[i] <= sync_f_q[i-1];
      end
      prev_t_q <= sync_t_q[SYNC_STAGES-1];
      prev_f_q <= sync_f_q[SYNC_STAGES-1];
    end
  end

  assign s_t = sync_t_q[SYNC_STAGES-1];
  assign s_f = sync_f_q[SYNC_STAGES-1];

  // A sample is only trusted once two consecutive synchronised values agree.
  assign stable  = (s_t == prev_t_q) && (s_f == prev_f_q);
  assign illegal = |(s_t & s_f);
  assign cdata   = &(s_t ^ s_f);
  assign cnull   = ~|(s_t | s_f);

  assign full = (level_q == LW'(DEPTH));
  assign pop  = out_valid_q & out_ready;

  always_comb begin
    state_d = state_q;
    push    = 1'b0;
    case (state_q)
      WAIT_DATA: begin
        if (stable && cdata && !full) begin
          push    = 1'b1;
          state_d = WAIT_NULL;
        end
      end
      WAIT_NULL: begin
        if (stable && cnull) state_d = WAIT_DATA;
      end
      default: state_d = WAIT_DATA;
    endcase
  end

  always_comb begin
    level_d = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  // Words pushed on this edge become visible one edge later; popped words disappear at once.
  assign out_valid_d = ((level_q - LW'(pop)) != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= WAIT_DATA;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      level_q     <= level_d;
      out_valid_q <= out_valid_d;
      err_q       <= err_q | (stable & illegal);
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (push) begin
      mem_q[wr_ptr_q] <= s_t;
    end
  end

  assign in_ack    = (state_q == WAIT_NULL);
  assign out_data  = mem_q[rd_ptr_q];
  assign out_valid = out_valid_q;
  assign level     = level_q;
  assign err       = err_q;

endmodule

// File: tb/tb_ncl_sync_fifo_bridge.sv
// Directed bench for ncl_sync_fifo_bridge: a queue-based reference model checked every cycle,
// plus hand-computed latency, backpressure, skew, illegal-code and async-reset expectations.
module tb_ncl_sync_fifo_bridge;

  localparam int W  = 8;
  localparam int D  = 4;
  localparam int S  = 2;
  localparam int LW = $clog2(D) + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [W-1:0]  in_t = '0;
  logic [W-1:0]  in_f = '0;
  logic          in_ack;
  logic [W-1:0]  out_data;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [LW-1:0] level;
  logic          err;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ncl_sync_fifo_bridge #(.WIDTH(W), .DEPTH(D), .SYNC_STAGES(S)) dut (
    .clk(clk), .rst_n(rst_n), .in_t(in_t), .in_f(in_f), .in_ack(in_ack),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .level(level), .err(err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: input history as a plain delay line, FIFO contents as a queue.
  logic [W-1:0] hq_t[$];
  logic [W-1:0] hq_f[$];
  logic [W-1:0] exp_q[$];
  logic [W-1:0] dut_pops[$];
  bit           m_ack, m_valid, m_err;

  task automatic model_reset();
    hq_t.delete();
    hq_f.delete();
    for (int i = 0; i <= S; i++) begin
      hq_t.push_back('0);
      hq_f.push_back('0);
    end
    exp_q.delete();
    m_ack   = 1'b0;
    m_valid = 1'b0;
    m_err   = 1'b0;
  endtask

  task automatic model_step();
    logic [W-1:0] st, sf;
    bit stable, ill, cdata, cnull, pop, push;
    int sz;
    st     = hq_t[1];
    sf     = hq_f[1];
    stable = (hq_t[0] == st) && (hq_f[0] == sf);
    ill    = (st & sf) != '0;
    cdata  = (st ^ sf) == {W{1'b1}};
    cnull  = (st | sf) == '0;
    sz     = exp_q.size();
    pop    = m_valid && out_ready;
    push   = !m_ack && stable && cdata && (sz < D);
    if (out_valid === 1'b1 && out_ready) dut_pops.push_back(out_data);
    if (stable && ill) m_err = 1'b1;
    if (push) m_ack = 1'b1;
    else if (m_ack && stable && cnull) m_ack = 1'b0;
    m_valid = (sz - int'(pop)) > 0;
    if (pop) void'(exp_q.pop_front());
    if (push) exp_q.push_back(st);
    hq_t.push_back(in_t);
    hq_f.push_back(in_f);
    void'(hq_t.pop_front());
    void'(hq_f.pop_front());
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) model_reset();
    else        model_step();
  end

  always @(negedge clk) begin
    if (rst_n) begin
      check("cyc_ack",   in_ack,    m_ack);
      check("cyc_valid", out_valid, m_valid);
      check("cyc_level", level,     exp_q.size());
      check("cyc_err",   err,       m_err);
      if (m_valid && exp_q.size() > 0) check("cyc_data", out_data, exp_q[0]);
    end
  end

  task automatic drive(input logic [W-1:0] t, input logic [W-1:0] f);
    in_t = t;
    in_f = f;
  endtask

  task automatic edges(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_ack(input logic v, input string name);
    int n;
    n = 0;
    while (in_ack !== v && n < 50) begin
      @(negedge clk);
      n++;
    end
    check(name, in_ack, v);
  endtask

  task automatic send(input logic [W-1:0] v);
    drive(v, ~v);
    wait_ack(1'b1, "send_ack");
    drive('0, '0);
    wait_ack(1'b0, "send_null");
  endtask

  initial begin
    logic [W-1:0] got;
    int n;
    edges(3);
    check("rst_ack", in_ack, 0);
    check("rst_valid", out_valid, 0);
    check("rst_level", level, 0);
    check("rst_data", out_data, 0);
    check("rst_err", err, 0);
    rst_n = 1'b1;
    edges(2);

    // DATA 0xA5: in_ack and push at E+S+1, out_valid at E+S+2
    drive(8'hA5, 8'h5A);
    edges(S + 1);
    check("s1_ack_early", in_ack, 0);
    edges(1);
    check("s1_ack", in_ack, 1);
    check("s1_level", level, 1);
    check("s1_valid_early", out_valid, 0);
    edges(1);
    check("s1_valid", out_valid, 1);
    check("s1_data", out_data, 8'hA5);

    // NULL releases the handshake after the same latency
    drive('0, '0);
    edges(S + 1);
    check("s2_ack_hold", in_ack, 1);
    edges(1);
    check("s2_ack", in_ack, 0);
    check("s2_level", level, 1);
    out_ready = 1'b1;
    edges(1);
    out_ready = 1'b0;
    check("s2_level_pop", level, 0);
    check("s2_valid_pop", out_valid, 0);
    check("s2_pop_cnt", dut_pops.size(), 1);
    got = (dut_pops.size() > 0) ? dut_pops[0] : 'x;
    check("s2_pop_data", got, 8'hA5);
    dut_pops.delete();

    // Fill to DEPTH, fifth token is held off until a pop frees a slot
    for (int v = 1; v <= 4; v++) send(W'(v));
    check("s3_full", level, 4);
    drive(8'h05, 8'hFA);
    edges(10);
    check("s3_bp_ack", in_ack, 0);
    check("s3_bp_level", level, 4);
    out_ready = 1'b1;
    edges(1);
    out_ready = 1'b0;
    check("s3_pop_level", level, 3);
    check("s3_pop_ack", in_ack, 0);
    edges(1);
    check("s3_push_ack", in_ack, 1);
    check("s3_push_level", level, 4);
    drive('0, '0);
    wait_ack(1'b0, "s3_null");
    out_ready = 1'b1;
    n = 0;
    while (level != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    out_ready = 1'b0;
    check("s3_drained", level, 0);
    check("s3_pop_cnt", dut_pops.size(), 5);
    for (int i = 0; i < 5; i++) begin
      got = (i < dut_pops.size()) ? dut_pops[i] : 'x;
      check("s3_pop_order", got, W'(i + 1));
    end

    // Skewed arrival: bit7 completes three cycles after the rest
    drive(8'h01, 8'h7E);
    edges(3);
    check("s4_partial_ack", in_ack, 0);
    check("s4_partial_level", level, 0);
    drive(8'h81, 8'h7E);
    edges(S + 1);
    check("s4_wait_level", level, 0);
    edges(1);
    check("s4_ack", in_ack, 1);
    check("s4_level", level, 1);
    edges(5);
    check("s4_once", level, 1);
    check("s4_data", out_data, 8'h81);
    drive('0, '0);
    wait_ack(1'b0, "s4_null");

    // Illegal code on bit3 sets the sticky error without a push
    drive(8'h08, 8'h08);
    edges(S + 1);
    check("s5_err_early", err, 0);
    edges(1);
    check("s5_err", err, 1);
    check("s5_ack", in_ack, 0);
    check("s5_level", level, 1);
    drive('0, '0);
    edges(5);
    check("s5_err_sticky", err, 1);
    check("s5_level_hold", level, 1);

    // Asynchronous reset while in WAIT_NULL with two words buffered
    drive(8'h3C, 8'hC3);
    wait_ack(1'b1, "s6_ack");
    check("s6_level", level, 2);
    #2 rst_n = 1'b0;
    #1;
    check("s6_rst_ack", in_ack, 0);
    check("s6_rst_valid", out_valid, 0);
    check("s6_rst_level", level, 0);
    check("s6_rst_err", err, 0);
    check("s6_rst_data", out_data, 0);
    edges(2);
    rst_n = 1'b1;
    edges(S + 1);
    check("s6_re_ack_early", in_ack, 0);
    edges(1);
    check("s6_re_ack", in_ack, 1);
    check("s6_re_level", level, 1);
    edges(1);
    check("s6_re_data", out_data, 8'h3C);
    drive('0, '0);
    wait_ack(1'b0, "s6_null");
    edges(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
